// File: rtl/calc1_pkg.sv
// Shared types for the calc1 port scheduler: command codes, response codes
// and per-port FSM states.
package calc1_pkg;

  localparam int unsigned CMD_BITS = 4;

  typedef enum logic [CMD_BITS-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_LSH = 4'd5,
    CMD_RSH = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_OVF  = 2'd2,
    RESP_INV  = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    PEND = 2'd2
  } port_state_e;

endpackage

// File: rtl/calc1_port_scheduler_if.sv
// Requester-side bus of the calc1 port scheduler: flat per-port command,
// operand, ready and response lanes.
interface calc1_port_scheduler_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CMD_W     = 4
);
  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in;
  logic [NUM_PORTS*DATA_W-1:0] req_data_in;
  logic [NUM_PORTS-1:0]        in_rdy;
  logic [NUM_PORTS*2-1:0]      out_resp;
  logic [NUM_PORTS*DATA_W-1:0] out_data;

  modport master (
    output req_cmd_in, req_data_in,
    input  in_rdy, out_resp, out_data
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    output in_rdy, out_resp, out_data
  );
endinterface

// File: rtl/calc1_port_fsm.sv
// Per-port request capture: latches cmd/op1, then op2, then holds the
// request pending until the arbiter grants it.
module calc1_port_fsm
  import calc1_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CMD_W  = 4
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  cmd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              grant_i,
  output logic              in_rdy_o,
  output logic              pend_o,
  output logic [CMD_W-1:0]  cmd_o,
  output logic [DATA_W-1:0] op1_o,
  output logic [DATA_W-1:0] op2_o
);

  port_state_e       state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    unique case (state_q)
      IDLE: if (cmd_i != CMD_W'(CMD_NOP)) begin
        state_d = OP2;
        cmd_d   = cmd_i;
        op1_d   = data_i;
      end
      OP2: begin
        op2_d   = data_i;
        state_d = PEND;
      end
      PEND: if (grant_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_rdy_o = (state_q == IDLE);
  assign pend_o   = (state_q == PEND);
  assign cmd_o    = cmd_q;
  assign op1_o    = op1_q;
  assign op2_o    = op2_q;

endmodule

// File: rtl/calc1_port_scheduler.sv
// calc1 port scheduler: per-port request FSMs sharing one registered ALU.
// Arbitration is round-robin by default; CALC1_FIXED_PRIO_EN selects fixed priority.
module calc1_port_scheduler
  import calc1_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CMD_W     = 4,
  parameter int unsigned SHIFT_W   = 5
) (
  input  logic                   c_clk,
  input  logic                   reset,
  calc1_port_scheduler_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] pend, grant, rdy;
  logic [CMD_W-1:0]     cmd_arr [NUM_PORTS];
  logic [DATA_W-1:0]    op1_arr [NUM_PORTS];
  logic [DATA_W-1:0]    op2_arr [NUM_PORTS];

  logic                 grant_vld;
  logic [IDX_W-1:0]     grant_idx;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign grant[g] = grant_vld && (grant_idx == IDX_W'(g));

    calc1_port_fsm #(
      .DATA_W (DATA_W),
      .CMD_W  (CMD_W)
    ) u_fsm (
      .c_clk    (c_clk),
      .reset    (reset),
      .cmd_i    (bus.req_cmd_in[g*CMD_W +: CMD_W]),
      .data_i   (bus.req_data_in[g*DATA_W +: DATA_W]),
      .grant_i  (grant[g]),
      .in_rdy_o (rdy[g]),
      .pend_o   (pend[g]),
      .cmd_o    (cmd_arr[g]),
      .op1_o    (op1_arr[g]),
      .op2_o    (op2_arr[g])
    );
  end

  assign bus.in_rdy = rdy;

`ifdef CALC1_FIXED_PRIO_EN
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (pend[IDX_W'(i)] && !grant_vld) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] cand;

  // Scan starts at the pointer and wraps; first pending port wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_PORTS);
      if (pend[cand] && !grant_vld) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_vld)
      rr_ptr_d = (grant_idx == IDX_W'(NUM_PORTS-1)) ? '0 : grant_idx + IDX_W'(1);
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  logic [CMD_W-1:0]  g_cmd;
  logic [DATA_W-1:0] g_op1, g_op2;
  logic [DATA_W:0]   sum;
  resp_e             alu_resp;
  logic [DATA_W-1:0] alu_data;

  always_comb begin
    g_cmd    = cmd_arr[grant_idx];
    g_op1    = op1_arr[grant_idx];
    g_op2    = op2_arr[grant_idx];
    sum      = {1'b0, g_op1} + {1'b0, g_op2};
    alu_resp = RESP_NONE;
    alu_data = '0;
    if (grant_vld) begin
      case (g_cmd)
        CMD_W'(CMD_ADD): begin
          if (sum[DATA_W]) alu_resp = RESP_OVF;
          else begin
            alu_resp = RESP_OK;
            alu_data = sum[DATA_W-1:0];
          end
        end
        CMD_W'(CMD_SUB): begin
          if (g_op2 > g_op1) alu_resp = RESP_OVF;
          else begin
            alu_resp = RESP_OK;
            alu_data = g_op1 - g_op2;
          end
        end
        CMD_W'(CMD_LSH): begin
          alu_resp = RESP_OK;
          alu_data = g_op1 << g_op2[SHIFT_W-1:0];
        end
        CMD_W'(CMD_RSH): begin
          alu_resp = RESP_OK;
          alu_data = g_op1 >> g_op2[SHIFT_W-1:0];
        end
        default: alu_resp = RESP_INV;
      endcase
    end
  end

  resp_e             res_resp_q;
  logic [DATA_W-1:0] res_data_q;
  logic [IDX_W-1:0]  res_idx_q;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      res_resp_q <= RESP_NONE;
      res_data_q <= '0;
      res_idx_q  <= '0;
    end else begin
      res_resp_q <= alu_resp;
      res_data_q <= alu_data;
      res_idx_q  <= grant_idx;
    end
  end

  logic [NUM_PORTS*2-1:0]      resp_vec;
  logic [NUM_PORTS*DATA_W-1:0] data_vec;

  always_comb begin
    resp_vec = '0;
    data_vec = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (res_idx_q == IDX_W'(i)) begin
        resp_vec[i*2 +: 2]           = res_resp_q;
        data_vec[i*DATA_W +: DATA_W] = res_data_q;
      end
    end
  end

  assign bus.out_resp = resp_vec;
  assign bus.out_data = data_vec;

endmodule

// File: tb/tb_calc1_port_scheduler.sv
// Directed bench for calc1_port_scheduler: expected responses (port, code,
// data, cycle) are queued at issue time and matched by a negedge monitor.
module tb_calc1_port_scheduler;

  logic c_clk = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic [1:0]  port;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [31:0] cyc;
  } rsp_t;

  rsp_t sb [$];

  calc1_port_scheduler_if #(.NUM_PORTS(4), .DATA_W(32), .CMD_W(4)) bus ();

  calc1_port_scheduler #(
    .NUM_PORTS (4),
    .DATA_W    (32),
    .CMD_W     (4),
    .SHIFT_W   (5)
  ) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every non-zero response must match the queue head.
  always @(negedge c_clk) begin
    if (reset === 1'b0) begin
      for (int i = 0; i < 4; i++) begin
        logic [1:0]  r;
        logic [31:0] d;
        rsp_t        obs, exp;
        r = bus.out_resp[i*2 +: 2];
        d = bus.out_data[i*32 +: 32];
        if (r !== 2'd0) begin
          obs = '{port: 2'(i), resp: r, data: d, cyc: 32'(cyc)};
          total++;
          if (sb.size() == 0) begin
            assert (r === 2'd0) else begin
              bad++;
              $error("FAIL unexpected_resp port=%0d observed=%0d expected=0", i, r);
            end
          end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
              bad++;
              $error("FAIL resp observed(port=%0d resp=%0d data=%h cyc=%0d) expected(port=%0d resp=%0d data=%h cyc=%0d)",
                     obs.port, obs.resp, obs.data, obs.cyc, exp.port, exp.resp, exp.data, exp.cyc);
            end
          end
        end else begin
          total++;
          assert (d === 32'd0) else begin
            bad++;
            $error("FAIL idle_data port=%0d observed=%h expected=0", i, d);
          end
        end
      end
    end
  end

  task automatic push_exp(input int p, input logic [1:0] r, input logic [31:0] d, input int at);
    sb.push_back('{port: 2'(p), resp: r, data: d, cyc: 32'(at)});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge c_clk);
  endtask

  // Called just after a negedge; returns at the negedge where the ports are PEND.
  task automatic drive(input logic [3:0] mask, input logic [3:0] cmd,
                       input logic [31:0] op1, input logic [31:0] op2, output int base);
    base = cyc;
    for (int p = 0; p < 4; p++)
      if (mask[p]) begin
        bus.req_cmd_in[p*4 +: 4]   = cmd;
        bus.req_data_in[p*32 +: 32] = op1;
      end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++)
      if (mask[p]) begin
        bus.req_cmd_in[p*4 +: 4]   = 4'd0;
        bus.req_data_in[p*32 +: 32] = op2;
      end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++)
      if (mask[p]) bus.req_data_in[p*32 +: 32] = 32'd0;
  endtask

  initial begin
    int b;
    bus.req_cmd_in  = '0;
    bus.req_data_in = '0;

    @(negedge c_clk);
    check("rst_in_rdy",   64'(bus.in_rdy),   64'hF);
    check("rst_out_resp", 64'(bus.out_resp), 64'h0);
    check("rst_out_data", 64'(bus.out_data[63:0]), 64'h0);
    reset = 1'b0;
    idle(2);

    // Basic ADD on port 0, three edges after the command
    drive(4'b0001, 4'd1, 32'hFFFF0000, 32'h0000FFFF, b);
    push_exp(0, 2'd1, 32'hFFFFFFFF, b + 3);
    check("pend_in_rdy", 64'(bus.in_rdy), 64'hE);
    idle(1);
    check("resp_in_rdy", 64'(bus.in_rdy), 64'hF);
    idle(1);

    // Overflow / underflow
    drive(4'b0100, 4'd1, 32'hFFFFFFFF, 32'h00000001, b);
    push_exp(2, 2'd2, 32'd0, b + 3);
    idle(2);
    drive(4'b1000, 4'd2, 32'h00000000, 32'h00000001, b);
    push_exp(3, 2'd2, 32'd0, b + 3);
    idle(2);

    // All four ports together, pointer at 0
    drive(4'b1111, 4'd1, 32'd1, 32'd1, b);
    for (int p = 0; p < 4; p++) push_exp(p, 2'd1, 32'd2, b + 3 + p);
    idle(5);

    // Pointer back at 0: port 0 ahead of port 3
    drive(4'b1001, 4'd1, 32'd10, 32'd20, b);
    push_exp(0, 2'd1, 32'd30, b + 3);
    push_exp(3, 2'd1, 32'd30, b + 4);
    idle(3);

    // Grant port 2 alone (pointer -> 3), then port 3 must beat port 1
    drive(4'b0100, 4'd1, 32'd5, 32'd6, b);
    push_exp(2, 2'd1, 32'd11, b + 3);
    idle(2);
    drive(4'b1010, 4'd1, 32'd7, 32'd8, b);
    push_exp(3, 2'd1, 32'd15, b + 3);
    push_exp(1, 2'd1, 32'd15, b + 4);
    idle(3);

    // Shifts, second command accepted in the response cycle of the first
    drive(4'b0010, 4'd5, 32'h00000001, 32'h0000003F, b);
    push_exp(1, 2'd1, 32'h80000000, b + 3);
    idle(1);
    check("b2b_in_rdy", 64'(bus.in_rdy), 64'hF);
    drive(4'b0010, 4'd6, 32'h80000000, 32'h00000004, b);
    push_exp(1, 2'd1, 32'h08000000, b + 3);
    idle(2);

    // SUB equal and ordinary
    drive(4'b0001, 4'd2, 32'd5, 32'd5, b);
    push_exp(0, 2'd1, 32'd0, b + 3);
    idle(2);
    drive(4'b0001, 4'd2, 32'd10, 32'd3, b);
    push_exp(0, 2'd1, 32'd7, b + 3);
    idle(2);

    // Invalid command; commands during OP2/PEND must be ignored
    b = cyc;
    bus.req_cmd_in[3:0]  = 4'd4;
    bus.req_data_in[31:0] = 32'h1234;
    push_exp(0, 2'd3, 32'd0, b + 3);
    @(negedge c_clk);
    bus.req_cmd_in[3:0]  = 4'd1;
    bus.req_data_in[31:0] = 32'd5;
    @(negedge c_clk);
    check("inv_pend_in_rdy", 64'(bus.in_rdy), 64'hE);
    bus.req_data_in[31:0] = 32'd6;
    @(negedge c_clk);
    check("inv_resp_in_rdy", 64'(bus.in_rdy), 64'hF);
    bus.req_cmd_in[3:0]  = 4'd0;
    bus.req_data_in[31:0] = 32'd0;
    idle(4);
    check("inv_no_extra", 64'(sb.size()), 64'd0);

    // Reset while all ports are pending: nothing may come out
    drive(4'b1111, 4'd1, 32'd9, 32'd9, b);
    reset = 1'b1;
    #1;
    check("async_rst_in_rdy", 64'(bus.in_rdy),   64'hF);
    check("async_rst_resp",   64'(bus.out_resp), 64'h0);
    #1;
    reset = 1'b0;
    @(negedge c_clk);
    check("post_rst_in_rdy", 64'(bus.in_rdy),   64'hF);
    check("post_rst_resp",   64'(bus.out_resp), 64'h0);
    idle(3);
    drive(4'b1000, 4'd1, 32'd2, 32'd3, b);
    push_exp(3, 2'd1, 32'd5, b + 3);
    idle(3);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
